instr_prefetch_buffer: RTL and testbench

Instruction prefetch buffer that sits directly upstream of the instruction aligner in the IF stage. It issues word-aligned OBI-style fetch requests to instruction memory and tracks outstanding transactions. Returned words are buffered in a FIFO and handed to the aligner over a valid/ready interface. On a branch it flushes the FIFO, discards stale in-flight responses and restarts fetching at the word containing the branch target.

---
 rtl/instr_prefetch_buffer.sv | 136 +++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// instr_prefetch_buffer
//   IF-stage prefetcher feeding the instruction aligner. Issues word-aligned
//   OBI-style fetches, tracks outstanding requests and buffers returned
//   words in a small FIFO. A branch flushes the FIFO, marks every in-flight
//   response as stale and restarts fetching at the target word.
//
// Parameters
//   DEPTH            FIFO entries (power of two, >= 2)
//   MAX_OUTSTANDING  granted-but-unanswered requests (1..DEPTH)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_i                      fetch enable
//   branch_i, branch_addr_i    redirect pulse and byte target
//   fetch_valid_o/rdata_o      FIFO head to the aligner
//   fetch_ready_i              aligner pops the head
//   instr_req_o/addr_o         memory request and word address
//   instr_gnt_i                request accepted
//   instr_rvalid_i/rdata_i     in-order response
//   busy_o                     request pending or responses outstanding
// ---------------------------------------------------------------------------
module instr_prefetch_buffer #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_rdata_o,
    input  logic        fetch_ready_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        busy_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned FW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = FW + 1;

    logic [31:0]   addr_q;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] disc_cnt;
    logic [CW-1:0] out_cnt_next;
    logic [FW-1:0] fifo_cnt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   mem [DEPTH];

    logic [SW-1:0] credit_sum;
    logic          grant;
    logic          rsp;
    logic          push;
    logic          pop;
    logic          unused_halfword_bits;

    always_comb begin
        credit_sum   = SW'(fifo_cnt) + SW'(out_cnt);
        // Counting outstanding requests against free FIFO slots guarantees
        // every response finds room, so pushes are never blocked.
        instr_req_o  = rst_n & req_i
                     & (out_cnt < CW'(MAX_OUTSTANDING))
                     & (credit_sum < SW'(DEPTH));
        grant        = instr_req_o & instr_gnt_i;
        // Responses with nothing outstanding are ignored so counters saturate.
        rsp          = instr_rvalid_i & (out_cnt != '0);
        out_cnt_next = out_cnt + CW'(grant) - CW'(rsp);
        push         = rsp & (disc_cnt == '0) & ~branch_i;
        pop          = fetch_valid_o & fetch_ready_i & ~branch_i;

        fetch_valid_o = (fifo_cnt != '0);
        fetch_rdata_o = fetch_valid_o ? mem[rd_ptr] : '0;
        instr_addr_o  = addr_q;
        busy_o        = instr_req_o | (out_cnt != '0);

        // The halfword offset belongs to the aligner; only whole words are fetched.
        unused_halfword_bits = ^branch_addr_i[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            out_cnt  <= '0;
            disc_cnt <= '0;
        end else begin
            out_cnt <= out_cnt_next;
            if (branch_i) begin
                addr_q   <= {branch_addr_i[31:2], 2'b00};
                // Everything still in flight, including a grant taken this
                // cycle at the old address, belongs to the abandoned stream.
                disc_cnt <= out_cnt_next;
            end else begin
                if (grant) begin
                    addr_q <= addr_q + 32'd4;
                end
                if (rsp && (disc_cnt != '0)) begin
                    disc_cnt <= disc_cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (branch_i) begin
            fifo_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_cnt <= fifo_cnt + FW'(push) - FW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= instr_rdata_i;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
module tb_instr_prefetch_buffer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAX_OUT = 2;

    logic        clk;
    logic        rst_n;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        fetch_valid_o;
    logic [31:0] fetch_rdata_o;
    logic        fetch_ready_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        busy_o;

    instr_prefetch_buffer #(
        .DEPTH          (DEPTH),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .fetch_valid_o (fetch_valid_o),
        .fetch_rdata_o (fetch_rdata_o),
        .fetch_ready_i (fetch_ready_i),
        .instr_req_o   (instr_req_o),
        .instr_addr_o  (instr_addr_o),
        .instr_gnt_i   (instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i (instr_rdata_i),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: requests in flight (oldest first) and delivered words.
    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] fifo_q[$];
    logic [31:0] m_addr;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0000_1235;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        fifo_q.delete();
        m_addr = '0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance
    // the model with what the memory side and consumer did. Entered and left
    // 1 time unit after a rising edge.
    task automatic step(input bit req, input bit br, input logic [31:0] baddr,
                        input bit rdy, input bit gnt, input bit rv_want);
        bit          rv;
        bit          e_req;
        bit          grant;
        pend_t       head;
        logic [31:0] e_rdata;

        rv = rv_want && (pend.size() > 0);
        req_i          = req;
        branch_i       = br;
        branch_addr_i  = baddr;
        fetch_ready_i  = rdy;
        instr_gnt_i    = gnt;
        instr_rvalid_i = rv;
        instr_rdata_i  = rv ? memw(pend[0].addr) : $urandom();

        e_req   = req && (pend.size() < MAX_OUT) && (fifo_q.size() + pend.size() < DEPTH);
        e_rdata = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
        #3;
        chk("instr_req", 32'(instr_req_o), 32'(e_req));
        chk("instr_addr", instr_addr_o, m_addr);
        chk("fetch_valid", 32'(fetch_valid_o), 32'(fifo_q.size() > 0));
        chk("fetch_rdata", fetch_rdata_o, e_rdata);
        chk("busy", 32'(busy_o), 32'(e_req || (pend.size() > 0)));

        grant = e_req && gnt;
        if (rv) head = pend.pop_front();
        if (br) begin
            fifo_q.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            if (grant) pend.push_back('{m_addr, 1'b1});
            m_addr = {baddr[31:2], 2'b00};
        end else begin
            if (rdy && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
            if (rv && !head.stale) fifo_q.push_back(memw(head.addr));
            if (grant) begin
                pend.push_back('{m_addr, 1'b0});
                m_addr = m_addr + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        bit found;

        // Reset: outputs idle even with fetch enabled.
        rst_n = 1'b0; req_i = 1'b1; branch_i = 1'b0; branch_addr_i = '0;
        fetch_ready_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
        model_reset();
        #3;
        chk("rst_req", 32'(instr_req_o), 32'h0);
        chk("rst_addr", instr_addr_o, 32'h0);
        chk("rst_valid", 32'(fetch_valid_o), 32'h0);
        chk("rst_rdata", fetch_rdata_o, 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Streaming from 0x100.
        step(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

        // Backpressure: credit stops requests at four buffered words.
        drain();
        step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("bp_addr", instr_addr_o, 32'h110);
        chk("bp_req", 32'(instr_req_o), 32'h0);
        chk("bp_head", fetch_rdata_o, memw(32'h100));
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

        // Flush with two in flight; halfword target fetches the word.
        drain();
        step(1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'h302, 1'b1, 1'b0, 1'b0);
        chk("flush_addr", instr_addr_o, 32'h300);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (fetch_valid_o) found = 1'b1;
            else step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        end
        chk("flush_seen", 32'(found), 32'h1);
        chk("flush_first", fetch_rdata_o, memw(32'h300));

        // Branch coincident with grant and response.
        drain();
        step(1'b1, 1'b1, 32'h3C, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'h500, 1'b1, 1'b1, 1'b1);
        chk("coinc_valid", 32'(fetch_valid_o), 32'h0);
        chk("coinc_addr", instr_addr_o, 32'h500);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (fetch_valid_o) found = 1'b1;
            else step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        end
        chk("coinc_seen", 32'(found), 32'h1);
        chk("coinc_first", fetch_rdata_o, memw(32'h500));

        // Address wrap.
        drain();
        step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("wrap_addr", instr_addr_o, 32'h0);
        chk("wrap_req", 32'(instr_req_o), 32'h1);
        repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(9, 0) != 0,
                 $urandom_range(15, 0) == 0,
                 $urandom(),
                 $urandom_range(9, 0) < 7,
                 $urandom_range(1, 0) == 1,
                 $urandom_range(9, 0) < 6);
        end

        // Asynchronous reset mid-burst with two outstanding.
        drain();
        step(1'b1, 1'b1, 32'h800, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(instr_req_o), 32'h0);
        chk("arst_addr", instr_addr_o, 32'h0);
        chk("arst_valid", 32'(fetch_valid_o), 32'h0);
        chk("arst_rdata", fetch_rdata_o, 32'h0);
        chk("arst_busy", 32'(busy_o), 32'h0);
        instr_gnt_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Stray response with nothing outstanding must not underflow.
        req_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        instr_rvalid_i = 1'b0;
        chk("stray_busy", 32'(busy_o), 32'h0);
        chk("stray_valid", 32'(fetch_valid_o), 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
